// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter.
// PARITY state exists only when UART_TX_CFG_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_CFG_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic logic par_on(input logic [1:0] m);
    return (m == PAR_EVEN) || (m == PAR_ODD);
  endfunction

endpackage

// File: rtl/wbit_fifo.sv
// First-word-fall-through word FIFO for the UART TX path.
// A write while full is accepted only if a pop happens in the same cycle.
module wbit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             re_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q;
  logic             do_rd, do_wr;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign dout_o  = mem_q[rp_q];
  assign do_rd   = re_i && !empty_o;
  assign do_wr   = we_i && (!full_o || do_rd);

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wp_q] <= din_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + AW'(1);
      if (do_rd) rp_q <= rp_q + AW'(1);
      if (do_wr && !do_rd)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (do_rd && !do_wr) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter with per-frame latched baud/parity/stop config.
// Define UART_TX_CFG_PARITY_EN to enable the parity bit and parity_mode_i.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [15:0]           baud_div_i,
  input  logic [1:0]            parity_mode_i,
  input  logic                  stop2_i,
  input  logic                  tx_en_i,
  input  logic                  tx_we_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  tx_bit_o
);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           div_q, div_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  stop2_q, stop2_d;
  logic                  snd_q, snd_d;
  logic                  tx_q, tx_d;

  logic                  pop, load, done, bit_end, can_start;
  logic [DATA_WIDTH-1:0] f_dout;
  logic                  f_empty, f_full;

`ifdef UART_TX_CFG_PARITY_EN
  logic pen_q, pen_d, par_q, par_d;
`else
  logic unused_par;
  assign unused_par = ^parity_mode_i;
`endif

  wbit_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (tx_we_i),
    .din_i   (din_i),
    .re_i    (pop),
    .dout_o  (f_dout),
    .empty_o (f_empty),
    .full_o  (f_full)
  );

  assign empty_o   = f_empty;
  assign full_o    = f_full;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done;
  assign tx_bit_o  = tx_q;
  assign can_start = tx_en_i && !f_empty;
  assign bit_end   = (cnt_q == div_q - 16'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    div_d   = div_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    stop2_d = stop2_q;
    snd_d   = snd_q;
    pop     = 1'b0;
    load    = 1'b0;
    done    = 1'b0;
`ifdef UART_TX_CFG_PARITY_EN
    pen_d   = pen_q;
    par_d   = par_q;
`endif
    if (bit_end) cnt_d = '0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (can_start) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          sh_d = {1'b1, sh_q[DATA_WIDTH-1:1]};
          if (idx_q == LAST) begin
            snd_d = 1'b0;
`ifdef UART_TX_CFG_PARITY_EN
            state_d = pen_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
`ifdef UART_TX_CFG_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !snd_q) begin
            snd_d = 1'b1;
          end else begin
            done = 1'b1;
            if (can_start) load = 1'b1;
            else state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start: config is captured here and frozen until the next start.
    if (load) begin
      pop     = 1'b1;
      state_d = START;
      cnt_d   = '0;
      sh_d    = f_dout;
      div_d   = (baud_div_i == '0) ? 16'd1 : baud_div_i;
      stop2_d = stop2_i;
      snd_d   = 1'b0;
`ifdef UART_TX_CFG_PARITY_EN
      pen_d   = par_on(parity_mode_i);
      par_d   = (^f_dout) ^ (parity_mode_i == PAR_ODD);
`endif
    end

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
`ifdef UART_TX_CFG_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '1;
      stop2_q <= 1'b0;
      snd_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      stop2_q <= stop2_d;
      snd_q   <= snd_d;
      tx_q    <= tx_d;
    end
  end

`ifdef UART_TX_CFG_PARITY_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pen_q <= 1'b0;
      par_q <= 1'b0;
    end else begin
      pen_q <= pen_d;
      par_q <= par_d;
    end
  end
`endif

endmodule
